periph_bus_arbiter: RTL

- Two-requester arbiter for the single-slave memory-mapped peripheral request bus, e.g. the timer.
- Lets the core data port (m0) and the debug/DMA port (m1) share one slave port.
- Per-cycle round-robin arbitration with a bounded bus lock, so a requester can run an uninterrupted read-modify-write sequence (read byte, flip bit, write back).
- Routes the slave's one-cycle-later response back to the requester that issued the request.

---
 rtl/periph_bus_arbiter_pkg.sv | 38 +++
 rtl/periph_bus_arbiter_arb_lock_fsm.sv | 80 ++++++++
 rtl/periph_bus_arbiter.sv | 73 +++++++
 3 files changed

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared widths, memory bus codes and the request record for the peripheral bus arbiter.
package periph_bus_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd2;

  // NONE and STALL are arbiter-only codes; the slave never returns them.
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK    = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_ERR   = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE  = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_STALL = 3'd3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wr_data;
    logic                   wr_en;
    logic [MEM_COUNT_W-1:0] count;
  } bus_req_t;

  function automatic bus_req_t req_mux(input logic g0, input logic g1,
                                       input bus_req_t r0, input bus_req_t r1);
    bus_req_t r;
    r = '0;
    if (g0)      r = r0;
    else if (g1) r = r1;
    return r;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_arb_lock_fsm.sv
// Round-robin grant with bounded bus lock; index 0 is m0, index 1 is m1.
module arb_lock_fsm
  import periph_bus_arbiter_pkg::*;
#(
  parameter int LOCK_MAX_CYCLES = 16
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_lock,
  output logic       grant_m0,
  output logic       grant_m1
);

  localparam int CNT_W = $clog2(LOCK_MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_pref_q, rr_pref_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]       gnt;
  logic             winner;

  always_comb begin
    gnt = 2'b00;
    if (state_q == ST_IDLE) begin
      if (&req_valid) gnt[rr_pref_q] = 1'b1;
      else            gnt = req_valid;
    end else begin
      // non-owner is shut out for the whole lock, even while the owner is idle
      gnt[owner_q] = req_valid[owner_q];
    end
  end

  assign winner = gnt[1];

  // grants are masked in reset so the slave sees an idle bus immediately
  assign grant_m0 = gnt[0] & aresetn;
  assign grant_m1 = gnt[1] & aresetn;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_pref_d  = rr_pref_q;
    lock_cnt_d = lock_cnt_q;
    if (state_q == ST_IDLE) begin
      if (|gnt) begin
        rr_pref_d = ~winner;
        if (req_lock[winner]) begin
          state_d    = ST_LOCKED;
          owner_d    = winner;
          lock_cnt_d = '0;
        end
      end
    end else begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
      if (lock_cnt_q == CNT_LAST || (gnt[owner_q] && !req_lock[owner_q])) begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
        rr_pref_d  = ~owner_q;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rr_pref_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_pref_q  <= rr_pref_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the single-slave peripheral bus: request mux plus registered response routing.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int LOCK_MAX_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_m0_req_valid,
  input  logic                   i_m0_req_lock,
  input  logic [ADDR_W-1:0]      i_m0_req_addr,
  input  logic [WORD_W-1:0]      i_m0_req_wr_data,
  input  logic                   i_m0_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_m0_req_count,
  input  logic                   i_m1_req_valid,
  input  logic                   i_m1_req_lock,
  input  logic [ADDR_W-1:0]      i_m1_req_addr,
  input  logic [WORD_W-1:0]      i_m1_req_wr_data,
  input  logic                   i_m1_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_m1_req_count,
  output logic [WORD_W-1:0]      o_m0_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_m0_res_code,
  output logic [WORD_W-1:0]      o_m1_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_m1_res_code,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code
);

  logic       grant_m0, grant_m1;
  bus_req_t   req_m0, req_m1, req_out;
  logic [1:0] resp_sel, stall_q;

  arb_lock_fsm #(.LOCK_MAX_CYCLES(LOCK_MAX_CYCLES)) u_lock_fsm (
    .clk       (clk),
    .aresetn   (aresetn),
    .req_valid ({i_m1_req_valid, i_m0_req_valid}),
    .req_lock  ({i_m1_req_lock,  i_m0_req_lock}),
    .grant_m0  (grant_m0),
    .grant_m1  (grant_m1)
  );

  assign req_m0  = {i_m0_req_addr, i_m0_req_wr_data, i_m0_req_wr_en, i_m0_req_count};
  assign req_m1  = {i_m1_req_addr, i_m1_req_wr_data, i_m1_req_wr_en, i_m1_req_count};
  assign req_out = req_mux(grant_m0, grant_m1, req_m0, req_m1);

  assign o_req_addr    = req_out.addr;
  assign o_req_wr_data = req_out.wr_data;
  assign o_req_wr_en   = req_out.wr_en;
  assign o_req_count   = req_out.count;

  // slave answers one cycle later, so remember who owned this cycle
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      resp_sel <= 2'b00;
      stall_q  <= 2'b00;
    end else begin
      resp_sel <= {grant_m1, grant_m0};
      stall_q  <= {i_m1_req_valid & ~grant_m1, i_m0_req_valid & ~grant_m0};
    end
  end

  assign o_m0_res_rd_data = resp_sel[0] ? i_res_rd_data : '0;
  assign o_m1_res_rd_data = resp_sel[1] ? i_res_rd_data : '0;
  assign o_m0_res_code    = resp_sel[0] ? i_res_code :
                            stall_q[0]  ? MEM_CODE_STALL : MEM_CODE_NONE;
  assign o_m1_res_code    = resp_sel[1] ? i_res_code :
                            stall_q[1]  ? MEM_CODE_STALL : MEM_CODE_NONE;

endmodule
